// File: rtl/foc_sched_pkg.sv
// Shared types and constants for the FOC control-loop scheduler.
//   sched_state_t : scheduler FSM states
//   COEF_*        : coefficient indices within one axis bank
//   widths        : coefficient index, period counter and overrun counter widths
package foc_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAULT = 3'd4
    } sched_state_t;

    localparam int unsigned COEF_P     = 0;
    localparam int unsigned COEF_I     = 1;
    localparam int unsigned COEF_D     = 2;
    localparam int unsigned N_COEF_MAX = 4;

    localparam int unsigned IDX_W      = 2;
    localparam int unsigned PERIOD_W   = 16;
    localparam int unsigned OVR_W      = 8;

endpackage

// File: rtl/foc_loop_scheduler_if.sv
// Scheduler <-> FOC core link: start/completion handshake, frozen samples
// and the core's PID coefficient write ports.
//   master : scheduler side (drives valid, samples, coefficient writes)
//   slave  : core side (drives ready)
interface foc_loop_scheduler_if #(
    parameter int unsigned D_WIDTH = 19
);
    logic                      valid;
    logic                      ready;
    logic signed [D_WIDTH-1:0] currA_in;
    logic signed [D_WIDTH-1:0] currB_in;
    logic signed [D_WIDTH-1:0] currC_in;
    logic signed [D_WIDTH-1:0] angle_in;
    logic                      pid_d_wen;
    logic                      pid_q_wen;
    logic        [D_WIDTH-1:0] pid_d_addr;
    logic        [D_WIDTH-1:0] pid_q_addr;
    logic signed [D_WIDTH-1:0] pid_d_data;
    logic signed [D_WIDTH-1:0] pid_q_data;

    modport master (
        output valid, currA_in, currB_in, currC_in, angle_in,
        output pid_d_wen, pid_q_wen, pid_d_addr, pid_q_addr, pid_d_data, pid_q_data,
        input  ready
    );

    modport slave (
        input  valid, currA_in, currB_in, currC_in, angle_in,
        input  pid_d_wen, pid_q_wen, pid_d_addr, pid_q_addr, pid_d_data, pid_q_data,
        output ready
    );
endinterface

// File: rtl/foc_coef_bank.sv
// Shadow PID coefficient bank: N_COEF entries per axis (d, q).
//   clk, rstb        : clock, async active-low reset (bank clears to 0)
//   wen/axis/wr_*    : single write port; indices >= N_COEF are dropped
//   rd_addr          : read index; rd_d_c/rd_q_c return both axes combinationally
module foc_coef_bank
    import foc_sched_pkg::*;
#(
    parameter int unsigned D_WIDTH = 19,
    parameter int unsigned N_COEF  = 3
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      wen,
    input  logic                      axis,
    input  logic        [IDX_W-1:0]   wr_addr,
    input  logic signed [D_WIDTH-1:0] wr_data,
    input  logic        [IDX_W-1:0]   rd_addr,
    output logic signed [D_WIDTH-1:0] rd_d_c,
    output logic signed [D_WIDTH-1:0] rd_q_c
);
    logic signed [D_WIDTH-1:0] bank_d [N_COEF];
    logic signed [D_WIDTH-1:0] bank_q [N_COEF];

    // Write port: only matching in-range indices update.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < N_COEF; i++) begin
                bank_d[i] <= '0;
                bank_q[i] <= '0;
            end
        end else if (wen) begin
            for (int i = 0; i < N_COEF; i++) begin
                if (wr_addr == IDX_W'(i)) begin
                    if (axis) bank_q[i] <= wr_data;
                    else      bank_d[i] <= wr_data;
                end
            end
        end
    end

    // Read port: both axes at one index, 0 when out of range.
    always_comb begin
        rd_d_c = '0;
        rd_q_c = '0;
        for (int i = 0; i < N_COEF; i++) begin
            if (rd_addr == IDX_W'(i)) begin
                rd_d_c = bank_d[i];
                rd_q_c = bank_q[i];
            end
        end
    end

endmodule

// File: rtl/foc_loop_scheduler.sv
// FOC control-loop scheduler: uploads shadow PID coefficients to the core,
// fires one start per control tick with frozen samples, supervises completion
// with a timeout and counts dropped ticks.
//   clk, rstb            : clock, async active-low reset
//   enable, loop_period  : run control; period in cycles (0 = no ticks)
//   cfg_*                : shadow coefficient writes and upload request
//   curr*_s, angle_s     : live samples
//   core (master)        : start/ready handshake, frozen samples, coefficient ports
//   busy, fault          : LOAD/RUN indicator, sticky timeout fault
//   fault_clr            : leaves FAULT
//   overrun_cnt          : saturating dropped-tick count
module foc_loop_scheduler
    import foc_sched_pkg::*;
#(
    parameter int unsigned D_WIDTH = 19,
    parameter int unsigned Q_BITS  = 15,
    parameter int unsigned N_COEF  = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      enable,
    input  logic [PERIOD_W-1:0]       loop_period,
    input  logic                      cfg_wen,
    input  logic                      cfg_axis,
    input  logic [IDX_W-1:0]          cfg_addr,
    input  logic signed [D_WIDTH-1:0] cfg_data,
    input  logic                      cfg_commit,
    input  logic signed [D_WIDTH-1:0] currA_s,
    input  logic signed [D_WIDTH-1:0] currB_s,
    input  logic signed [D_WIDTH-1:0] currC_s,
    input  logic signed [D_WIDTH-1:0] angle_s,
    foc_loop_scheduler_if.master      core,
    output logic                      busy,
    output logic                      fault,
    input  logic                      fault_clr,
    output logic [OVR_W-1:0]          overrun_cnt
);
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEF - 1);

    if (Q_BITS >= D_WIDTH || N_COEF == 0 || N_COEF > N_COEF_MAX) begin : g_param_check
        $error("foc_loop_scheduler: unsupported parameter set");
    end

    sched_state_t              state, state_d;
    logic [IDX_W-1:0]          idx, idx_d;
    logic [TO_W-1:0]           to_cnt, to_cnt_d;
    logic [PERIOD_W-1:0]       per_cnt, per_cnt_d;
    logic                      commit_pend, pend_d;
    logic                      tick_c;
    logic [OVR_W-1:0]          ovr_d;
    logic                      valid_d, wen_d, busy_d, fault_d;
    logic [D_WIDTH-1:0]        addr_d;
    logic signed [D_WIDTH-1:0] data_d_d, data_q_d;
    logic signed [D_WIDTH-1:0] a_d, b_d, c_d, ang_d;
    logic signed [D_WIDTH-1:0] rd_d_c, rd_q_c;

    // Shadow bank; host writes are dropped while an upload is in flight.
    foc_coef_bank #(
        .D_WIDTH (D_WIDTH),
        .N_COEF  (N_COEF)
    ) u_bank (
        .clk     (clk),
        .rstb    (rstb),
        .wen     (cfg_wen && (state != ST_LOAD)),
        .axis    (cfg_axis),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_addr (idx_d),
        .rd_d_c  (rd_d_c),
        .rd_q_c  (rd_q_c)
    );

    // Period counter: wraps at loop_period-1, held at 0 when disabled or period is 0.
    always_comb begin
        per_cnt_d = '0;
        tick_c    = 1'b0;
        if (enable && (loop_period != '0)) begin
            tick_c = (per_cnt == loop_period - 16'd1);
            if (per_cnt < loop_period - 16'd1) per_cnt_d = per_cnt + 16'd1;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d  = state;
        idx_d    = '0;
        to_cnt_d = '0;
        pend_d   = commit_pend;
        ovr_d    = overrun_cnt;
        valid_d  = 1'b0;
        wen_d    = 1'b0;
        busy_d   = 1'b0;
        fault_d  = 1'b0;
        addr_d   = '0;
        a_d      = core.currA_in;
        b_d      = core.currB_in;
        c_d      = core.currC_in;
        ang_d    = core.angle_in;

        case (state)
            ST_IDLE: begin
                if (enable) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (idx == LAST_IDX) state_d = ST_ARM;
            end
            ST_ARM: begin
                // A pending upload takes priority over the tick.
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (commit_pend) begin
                    state_d = ST_LOAD;
                end else if (tick_c) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    a_d     = currA_s;
                    b_d     = currB_s;
                    c_d     = currC_s;
                    ang_d   = angle_s;
                end
            end
            ST_RUN: begin
                // Completion wins over a simultaneous timeout.
                if (core.ready) begin
                    state_d = commit_pend ? ST_LOAD : ST_ARM;
                end else if (to_cnt == TO_W'(TIMEOUT)) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (fault_clr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state == ST_LOAD && state_d == ST_LOAD) idx_d = idx + 1'b1;
        if (state == ST_RUN && state_d == ST_RUN) to_cnt_d = to_cnt + 1'b1;

        if (state == ST_LOAD) begin
            if (state_d != ST_LOAD) pend_d = 1'b0;
        end else if (cfg_commit) begin
            pend_d = 1'b1;
        end

        // Any tick that does not launch a cycle is a dropped tick.
        if (tick_c && !valid_d && (overrun_cnt != '1)) ovr_d = overrun_cnt + 1'b1;

        wen_d   = (state_d == ST_LOAD);
        busy_d  = (state_d == ST_LOAD) || (state_d == ST_RUN);
        fault_d = (state_d == ST_FAULT);
        if (wen_d) addr_d = D_WIDTH'(idx_d);
    end

    // Coefficient data follows the bank read at the upcoming LOAD index.
    always_comb begin
        data_d_d = '0;
        data_q_d = '0;
        if (wen_d) begin
            data_d_d = rd_d_c;
            data_q_d = rd_q_c;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Counters and registered outputs.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            idx             <= '0;
            to_cnt          <= '0;
            per_cnt         <= '0;
            commit_pend     <= 1'b0;
            overrun_cnt     <= '0;
            busy            <= 1'b0;
            fault           <= 1'b0;
            core.valid      <= 1'b0;
            core.currA_in   <= '0;
            core.currB_in   <= '0;
            core.currC_in   <= '0;
            core.angle_in   <= '0;
            core.pid_d_wen  <= 1'b0;
            core.pid_q_wen  <= 1'b0;
            core.pid_d_addr <= '0;
            core.pid_q_addr <= '0;
            core.pid_d_data <= '0;
            core.pid_q_data <= '0;
        end else begin
            idx             <= idx_d;
            to_cnt          <= to_cnt_d;
            per_cnt         <= per_cnt_d;
            commit_pend     <= pend_d;
            overrun_cnt     <= ovr_d;
            busy            <= busy_d;
            fault           <= fault_d;
            core.valid      <= valid_d;
            core.currA_in   <= a_d;
            core.currB_in   <= b_d;
            core.currC_in   <= c_d;
            core.angle_in   <= ang_d;
            core.pid_d_wen  <= wen_d;
            core.pid_q_wen  <= wen_d;
            core.pid_d_addr <= addr_d;
            core.pid_q_addr <= addr_d;
            core.pid_d_data <= data_d_d;
            core.pid_q_data <= data_q_d;
        end
    end

endmodule
